alu16_sequencer: RTL and testbench
==================================

Name: alu16_sequencer

Overview:
- Multi-cycle controller that issues 16-bit operations to the existing 8-bit combinational ALU, one byte per pass.
- Sits between the CPU execute stage and the 8-bit ALU.
- Accepts a request over valid/ready, drives the ALU low byte then high byte, and adds a fix-up pass to propagate ADD carry.
- Returns the 16-bit result plus Carry and Zero flags over valid/ready.

Parameters:
- none. Data width is fixed at 16 bits over an 8-bit ALU; op codes live in the shared package.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  3  operation code (package constants).
- req_a  input  16  operand A.
- req_b  input  16  operand B.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  16  16-bit result.
- rsp_carry  output  1  carry out of bit 15 (ADD only).
- rsp_zero  output  1  rsp_result == 0.
- rsp_err  output  1  req_op was illegal.
- alu_a  output  8  to ALU A.
- alu_b  output  8  to ALU B.
- alu_code  output  3  to ALU_Code.
- alu_out  input  8  from ALU_Out.
- alu_carry  input  1  from ALU Carry.
- alu_zero  input  1  from ALU isZero. Unused for flags; Zero is recomputed on 16 bits.

Behaviour:
- Reset (synchronous, active-high): state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_code=OP_ADD.
- States: IDLE, LO, HI, FIX, DONE.
- req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready; op, A and B are latched.
- Accepting a legal op moves IDLE->LO. Accepting an illegal op (100-111) moves IDLE->DONE with result=0, carry=0, zero=1, err=1.
- The ALU is combinational. The sequencer drives alu_* from registered state and samples alu_out/alu_carry at the end of the same cycle.
- LO: drive A[7:0], B[7:0], op. Capture lo byte and lo_carry. Go to HI.
- HI: drive A[15:8], B[15:8], op. Capture hi byte and hi_carry.
  - If op==ADD && lo_carry: go to FIX.
  - Otherwise: go to DONE.
- FIX: drive hi byte, 8'h01, OP_ADD. Replace hi byte with alu_out; fix_carry=alu_carry. Go to DONE.
- DONE: rsp_valid=1 and rsp_* stable until rsp_ready. On handshake go to IDLE; req_ready rises the following cycle (no same-cycle turnaround).
- rsp_carry = (op==ADD) & (hi_carry | fix_carry). Forced 0 for logic ops.
- rsp_zero = ({hi,lo}==16'h0000).
- Latency from the accept edge to rsp_valid high:
  - 3 cycles: ADD without low carry, and all logic ops.
  - 4 cycles: ADD with low carry.
  - 1 cycle: illegal op.
- Backpressure: DONE holds indefinitely; alu_* outputs are don't-care in IDLE/DONE but held at their last values.
- req_* changes while not in IDLE are ignored.
- Reset asserted in any state overrides everything: any in-flight op is dropped, no response is produced, and reset values apply at that edge.

Decomposition:
- Shared package alu_pkg:
  - OP_ADD=3'b000, OP_AND=3'b001, OP_OR=3'b010, OP_XOR=3'b011; 100-111 illegal.
  - State enum constants.
  - Byte-width constant 8.
- No sub-module. The ALU itself is instantiated alongside the sequencer at the execute-stage level, not inside it. The bench instantiates both.

Test Plan:
- ADD 0x1234+0x0101, rsp_ready=1:
  - rsp_result=0x1335, carry=0, zero=0, err=0.
  - rsp_valid exactly 3 cycles after accept; no FIX pass (alu_b never 0x01 with alu_a=0x13).
- ADD 0x00FF+0x0001:
  - LO gives 0x00 with carry; FIX pass drives alu_a=0x00, alu_b=0x01.
  - Result 0x0100, carry=0, zero=0; latency 4.
- ADD 0xFFFF+0x0001:
  - Result 0x0000, carry=1, zero=1; latency 4.
- XOR 0xA5A5^0xA5A5, then AND 0xF0F0&0x0FFF:
  - XOR: result 0x0000, zero=1, carry=0.
  - AND: result 0x00F0, zero=0.
  - Both at latency 3.
- Illegal op 3'b110, A=0xFFFF:
  - rsp_valid 1 cycle after accept; result 0, zero=1, carry=0, err=1.
  - No LO/HI pass occurs.
- Backpressure plus reset:
  - Hold rsp_ready=0 for 5 cycles: rsp_* stable and req_ready=0 throughout.
  - Then assert reset during a LO state: next cycle IDLE, req_ready=1, rsp_valid=0.
  - No stale response appears.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and byte width shared by the 16-bit sequencer
package alu_pkg;
  localparam int BYTE_W = 8;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;
  function automatic logic is_legal(input logic [2:0] op);
    return !op[2];
  endfunction
endpackage

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs 16-bit ops through an external 8-bit ALU, low byte, high byte, then a carry fix-up pass
module alu16_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [15:0]       req_a,
  input  logic [15:0]       req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [BYTE_W-1:0] alu_a,
  output logic [BYTE_W-1:0] alu_b,
  output logic [2:0]        alu_code,
  input  logic [BYTE_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero
);
  state_t state, state_n;
  logic [2:0] op;
  logic [BYTE_W-1:0] a_hi, b_hi, lo;
  logic lo_carry, hi_carry, accept, need_fix, unused;
  assign unused = alu_zero;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign accept = req_valid && req_ready;
  assign need_fix = op == OP_ADD && lo_carry;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (is_legal(req_op) ? LO : DONE) : IDLE) :
              state == LO   ? HI :
              state == HI   ? (need_fix ? FIX : DONE) :
              state == FIX  ? DONE :
              (rsp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // alu_* are registered so the ALU sees stable operands for the whole pass
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= OP_ADD;
      a_hi <= '0;
      b_hi <= '0;
      lo <= '0;
      lo_carry <= 1'b0;
      hi_carry <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_code <= OP_ADD;
      rsp_result <= '0;
      rsp_carry <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (is_legal(req_op)) begin
            op <= req_op;
            a_hi <= req_a[15:8];
            b_hi <= req_b[15:8];
            alu_a <= req_a[7:0];
            alu_b <= req_b[7:0];
            alu_code <= req_op;
            rsp_err <= 1'b0;
          end else begin
            rsp_result <= '0;
            rsp_carry <= 1'b0;
            rsp_zero <= 1'b1;
            rsp_err <= 1'b1;
          end
        end
        LO: begin
          lo <= alu_out;
          lo_carry <= alu_carry;
          alu_a <= a_hi;
          alu_b <= b_hi;
        end
        HI: begin
          hi_carry <= alu_carry;
          if (need_fix) begin
            alu_a <= alu_out;
            alu_b <= 8'h01;
            alu_code <= OP_ADD;
          end else begin
            rsp_result <= {alu_out, lo};
            rsp_carry <= op == OP_ADD && alu_carry;
            rsp_zero <= {alu_out, lo} == 16'h0000;
          end
        end
        FIX: begin
          rsp_result <= {alu_out, lo};
          rsp_carry <= hi_carry | alu_carry;
          rsp_zero <= {alu_out, lo} == 16'h0000;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: directed table, random ops and reset/backpressure sequences against a behavioural 16-bit model
module tb_alu16_sequencer;
  import alu_pkg::*;
  logic clk = 0, reset = 1, req_valid = 0, rsp_ready = 1;
  logic req_ready, rsp_valid, rsp_carry, rsp_zero, rsp_err, alu_carry, alu_zero;
  logic [2:0] req_op = 0, alu_code;
  logic [15:0] req_a = 0, req_b = 0, rsp_result;
  logic [7:0] alu_a, alu_b, alu_out;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  alu16_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b),
    .alu_code(alu_code), .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  // the external 8-bit combinational ALU
  always_comb begin
    {alu_carry, alu_out} = 9'h000;
    case (alu_code)
      OP_ADD: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      default: ;
    endcase
    alu_zero = alu_out == 8'h00;
  end

  typedef struct {
    logic [2:0] op; logic [15:0] a, b;
    logic [15:0] res; logic c, z, e; int lat; int hold;
  } vec_t;

  function automatic vec_t model(input logic [2:0] op, input logic [15:0] a, b);
    vec_t v;
    logic [16:0] s;
    v.op = op; v.a = a; v.b = b; v.c = 0; v.e = 0; v.lat = 3; v.hold = 0;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin
        v.res = s[15:0]; v.c = s[16];
        if ({1'b0, a[7:0]} + {1'b0, b[7:0]} > 9'd255) v.lat = 4;
      end
      OP_AND: v.res = a & b;
      OP_OR:  v.res = a | b;
      OP_XOR: v.res = a ^ b;
      default: begin v.res = 0; v.e = 1; v.lat = 1; end
    endcase
    v.z = v.res == 0;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string n);
    int t, lat;
    logic seq_ok, stable;
    logic [18:0] pre, exp_pass;
    logic [19:0] snap;
    logic [7:0] hs;
    hs = v.a[15:8] + v.b[15:8];
    t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk({n, "_ready"}, req_ready, 1);
    rsp_ready = v.hold == 0;
    req_op = v.op; req_a = v.a; req_b = v.b; req_valid = 1;
    pre = {alu_a, alu_b, alu_code};
    @(posedge clk); #1;
    req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    lat = 1; seq_ok = 1;
    while (!rsp_valid && lat < 10) begin
      exp_pass = lat == 1 ? {v.a[7:0], v.b[7:0], v.op} :
                 lat == 2 ? {v.a[15:8], v.b[15:8], v.op} : {hs, 8'h01, OP_ADD};
      if ({alu_a, alu_b, alu_code} !== exp_pass || lat > 3) seq_ok = 0;
      @(posedge clk); #1; lat++;
    end
    req_valid = 0;
    chk({n, "_lat"}, lat, v.lat);
    chk({n, "_res"}, rsp_result, v.res);
    chk({n, "_flags"}, {rsp_carry, rsp_zero, rsp_err}, {v.c, v.z, v.e});
    if (v.e) chk({n, "_no_pass"}, {alu_a, alu_b, alu_code}, pre);
    else chk({n, "_alu_seq"}, seq_ok, 1);
    if (v.hold > 0) begin
      snap = {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err};
      stable = 1;
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
        if ({rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err} !== snap || req_ready) stable = 0;
      end
      chk({n, "_hold"}, stable, 1);
      rsp_ready = 1;
    end
    @(posedge clk); #1;
    chk({n, "_after"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  vec_t tbl [10];
  initial begin
    logic clean;
    tbl[0] = '{OP_ADD, 16'h1234, 16'h0101, 16'h1335, 0, 0, 0, 3, 0};
    tbl[1] = '{OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 4, 0};
    tbl[2] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 4, 0};
    tbl[3] = '{OP_XOR, 16'hA5A5, 16'hA5A5, 16'h0000, 0, 1, 0, 3, 0};
    tbl[4] = '{OP_AND, 16'hF0F0, 16'h0FFF, 16'h00F0, 0, 0, 0, 3, 0};
    tbl[5] = '{OP_OR,  16'h1200, 16'h0034, 16'h1234, 0, 0, 0, 3, 0};
    tbl[6] = '{3'b110, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 1, 1, 0};
    tbl[7] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1, 1, 0, 3, 0};
    tbl[8] = '{OP_ADD, 16'h0080, 16'h0080, 16'h0100, 0, 0, 0, 4, 0};
    tbl[9] = '{OP_XOR, 16'hFFFF, 16'h1234, 16'hEDCB, 0, 0, 0, 3, 5};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hs", {req_ready, rsp_valid}, 2'b10);
    chk("reset_rsp", {rsp_result, rsp_carry, rsp_zero, rsp_err}, 19'h0);
    chk("reset_alu", {alu_a, alu_b, alu_code}, {16'h0, OP_ADD});
    reset = 0;
    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v = model(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      if (i % 8 == 0) v.a[7:0] = 8'hFF;
      v = model(v.op, v.a, v.b);
      v.hold = $urandom_range(0, 2);
      run(v, $sformatf("rnd%0d", i));
    end
    req_op = OP_ADD; req_a = 16'h00FF; req_b = 16'h0001; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_lo_state", {req_ready, rsp_valid}, 2'b10);
    chk("rst_lo_rsp", {rsp_result, rsp_carry, rsp_zero, rsp_err}, 19'h0);
    clean = 1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid || !req_ready) clean = 0;
    end
    chk("rst_no_stale", clean, 1);
    run(model(OP_ADD, 16'h0101, 16'h0202), "post_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
